// File: rtl/rep5_pkg.sv
// Shared definitions for the repetition-coded serial transmitter:
// default geometry, FSM state encoding and a counter-width helper.
package rep5_pkg;

  localparam int REP_DEFAULT    = 5;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A modulo-1 counter still needs one flop to hold its single value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rep5_serial_tx_if.sv
// Word-in / chip-out handshake bundle; master drives words and tx_ready,
// slave (the transmitter) returns data_ready and the chip stream.
interface rep5_serial_tx_if
  import rep5_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              tx_bit;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sof;

  modport master (
    output data_in, data_valid, tx_ready,
    input  data_ready, tx_bit, tx_valid, tx_sof
  );

  modport slave (
    input  data_in, data_valid, tx_ready,
    output data_ready, tx_bit, tx_valid, tx_sof
  );

endinterface

// File: rtl/rep_mod_counter.sv
// Modulo-N counter with synchronous clear, count enable and terminal-count flag.
// Latency: count updates on the edge where en is sampled; tc is decoded from count.
// Backpressure: none; holds its value whenever en is low.
module rep_mod_counter
  import rep5_pkg::*;
#(
  parameter int N = REP_DEFAULT,
  localparam int W = cnt_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/rep5_serial_tx.sv
// Serialises DATA_W-bit words LSB first, each bit repeated REP times as chips.
// Latency: first chip valid the cycle after the accept edge; done one cycle after last chip.
// Backpressure: tx_ready low freezes chip, sof and counters; data_ready low until back in IDLE.
module rep5_serial_tx
  import rep5_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int REP    = REP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  rep5_serial_tx_if.slave bus,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] SEND = ST_SEND;
  localparam logic [1:0] DONE = ST_DONE;

  localparam int CW = cnt_w(REP);
  localparam int BW = cnt_w(DATA_W);

  logic [1:0]        state;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     chip_cnt;
  logic [BW-1:0]     bit_cnt;
  logic              chip_tc;
  logic              bit_tc;
  logic              accept;
  logic              xfer;
  logic              chip_wrap;

  assign accept    = (state == IDLE) & bus.data_valid;
  assign xfer      = (state == SEND) & bus.tx_ready;
  assign chip_wrap = xfer & chip_tc;

  rep_mod_counter #(.N(REP)) u_chip_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (xfer),
    .count (chip_cnt),
    .tc    (chip_tc)
  );

  rep_mod_counter #(.N(DATA_W)) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (chip_wrap),
    .count (bit_cnt),
    .tc    (bit_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= bus.data_in;
            state <= SEND;
          end
        end
        SEND: begin
          if (chip_wrap) begin
            shreg <= shreg >> 1;
            if (bit_tc) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // data_ready is masked by rst so nothing looks acceptable while held in reset.
  assign bus.data_ready = (state == IDLE) & ~rst;
  assign bus.tx_valid   = (state == SEND);
  assign bus.tx_bit     = shreg[0];
  assign bus.tx_sof     = (state == SEND) && (chip_cnt == '0) && (bit_cnt == '0);
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);

endmodule

// File: tb/tb_rep5_serial_tx.sv
// Bench for rep5_serial_tx: scenario tasks compared against a word-to-chip reference.
module tb_rep5_serial_tx;

  localparam int DW  = 8;
  localparam int RP  = 5;
  localparam int NCH = DW * RP;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
  int   n_pass  = 0;
  int   n_total = 0;

  rep5_serial_tx_if #(.DATA_W(DW)) bus ();

  rep5_serial_tx #(.DATA_W(DW), .REP(RP)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // Reference: chip i carries data bit i/REP, LSB first.
  function automatic logic [NCH-1:0] exp_chips(input logic [DW-1:0] w);
    logic [NCH-1:0] e;
    for (int i = 0; i < NCH; i++) e[i] = w[i / RP];
    return e;
  endfunction

  // Waits for data_ready at a negedge, then offers w for one accept edge.
  task automatic start_word(input logic [DW-1:0] w, input bit hold_valid, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.data_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold_valid) bus.data_valid = 1'b0;
  endtask

  // Drives tx_ready (stall_pct % of cycles low) and records transferred chips.
  task automatic collect(input int stall_pct, input int max_chips,
                         output logic [NCH-1:0] chips, output logic [NCH-1:0] sofs,
                         output int nchips, output int first_idx, output int done_gap,
                         output int stall_bad, output int busy_bad, output bit timeout);
    bit pv, pb, ps, pr, r;
    int last_x;
    pv = 0; pb = 0; ps = 0; pr = 1; last_x = -100;
    chips = '0; sofs = '0; nchips = 0; first_idx = -1; done_gap = -1;
    stall_bad = 0; busy_bad = 0; timeout = 1'b1;
    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(negedge clk);
      if (pv && !pr && bus.tx_valid && (bus.tx_bit !== pb || bus.tx_sof !== ps)) stall_bad++;
      if (bus.tx_valid && !busy) busy_bad++;
      if (bus.tx_valid && first_idx < 0) first_idx = cyc;
      if (done) begin
        done_gap = cyc - last_x;
        timeout  = 1'b0;
        break;
      end
      r = ($urandom_range(0, 99) >= stall_pct);
      bus.tx_ready = r;
      pv = bus.tx_valid; pb = bus.tx_bit; ps = bus.tx_sof; pr = r;
      if (bus.tx_valid && r) begin
        if (nchips < NCH) begin
          chips[nchips] = bus.tx_bit;
          sofs[nchips]  = bus.tx_sof;
        end
        nchips++;
        last_x = cyc;
        if (nchips == max_chips) begin
          timeout = 1'b0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1; bus.data_valid = 1'b0; bus.data_in = '0; bus.tx_ready = 1'b0;
    #12;
    n_total++; if ({bus.data_ready, bus.tx_valid, busy, done} !== 4'b0) $display("FAIL reset_hold got=%b exp=0000", {bus.data_ready, bus.tx_valid, busy, done}); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.data_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", bus.data_ready); else n_pass++;
    start_word(8'hA5, 1'b0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL reset_accept_timeout got=%b exp=1", ok); else n_pass++;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_total++; if ({bus.tx_valid, bus.tx_bit, busy} !== 3'b111) $display("FAIL reset_pre_busy got=%b exp=111", {bus.tx_valid, bus.tx_bit, busy}); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if ({bus.data_ready, bus.tx_valid, bus.tx_bit, bus.tx_sof, busy, done} !== 6'b0) $display("FAIL reset_async got=%b exp=000000", {bus.data_ready, bus.tx_valid, bus.tx_bit, bus.tx_sof, busy, done}); else n_pass++;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({bus.data_ready, bus.tx_valid} !== 2'b10) $display("FAIL reset_after_release got=%b exp=10", {bus.data_ready, bus.tx_valid}); else n_pass++;
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_idle_ready();
    int bad;
    bad = 0;
    bus.tx_ready = 1'b1; bus.data_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_valid || busy || done || !bus.data_ready) bad++;
    end
    n_total++; if (bad !== 0) $display("FAIL idle_tx_ready bad_cycles=%0d exp=0", bad); else n_pass++;
  endtask

  task automatic test_a5();
    logic [NCH-1:0] ch, sf;
    int n, fi, dg, sb, bb;
    bit to, ok;
    start_word(8'hA5, 1'b0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL a5_accept_timeout got=%b exp=1", ok); else n_pass++;
    collect(0, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    n_total++; if (to !== 1'b0) $display("FAIL a5_timeout got=%b exp=0", to); else n_pass++;
    n_total++; if (n !== NCH) $display("FAIL a5_count got=%0d exp=%0d", n, NCH); else n_pass++;
    n_total++; if (ch !== exp_chips(8'hA5)) $display("FAIL a5_chips got=%h exp=%h", ch, exp_chips(8'hA5)); else n_pass++;
    n_total++; if (sf !== 40'h1) $display("FAIL a5_sof got=%h exp=%h", sf, 40'h1); else n_pass++;
    n_total++; if (fi !== 1) $display("FAIL a5_first_latency got=%0d exp=1", fi); else n_pass++;
    n_total++; if (dg !== 1) $display("FAIL a5_done_gap got=%0d exp=1", dg); else n_pass++;
    n_total++; if (bb !== 0) $display("FAIL a5_busy got=%0d exp=0", bb); else n_pass++;
    @(negedge clk);
    n_total++; if ({done, busy, bus.data_ready} !== 3'b001) $display("FAIL a5_done_pulse got=%b exp=001", {done, busy, bus.data_ready}); else n_pass++;
  endtask

  task automatic test_stall();
    logic [NCH-1:0] ch, sf;
    int n, fi, dg, sb, bb;
    bit to, ok;
    start_word(8'h3C, 1'b0, ok);
    collect(50, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    n_total++; if ({ok, to} !== 2'b10) $display("FAIL stall_timeout got=%b exp=10", {ok, to}); else n_pass++;
    n_total++; if (n !== NCH) $display("FAIL stall_count got=%0d exp=%0d", n, NCH); else n_pass++;
    n_total++; if (ch !== exp_chips(8'h3C)) $display("FAIL stall_chips got=%h exp=%h", ch, exp_chips(8'h3C)); else n_pass++;
    n_total++; if (sf !== 40'h1) $display("FAIL stall_sof got=%h exp=%h", sf, 40'h1); else n_pass++;
    n_total++; if (sb !== 0) $display("FAIL stall_hold changes=%0d exp=0", sb); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [NCH-1:0] ch, sf;
    int n, fi, dg, sb, bb;
    bit to, ok;
    start_word(8'h01, 1'b1, ok);
    bus.data_in = 8'hFF;
    collect(0, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    n_total++; if ({ok, to, n} !== {2'b10, 32'(NCH)}) $display("FAIL b2b_first_count got=%0d ok=%b to=%b exp=%0d", n, ok, to, NCH); else n_pass++;
    n_total++; if (ch !== exp_chips(8'h01)) $display("FAIL b2b_first_chips got=%h exp=%h", ch, exp_chips(8'h01)); else n_pass++;
    n_total++; if (bus.data_ready !== 1'b0) $display("FAIL b2b_ready_in_done got=%b exp=0", bus.data_ready); else n_pass++;
    @(negedge clk);
    n_total++; if ({bus.data_ready, bus.tx_valid, done} !== 3'b100) $display("FAIL b2b_idle_cycle got=%b exp=100", {bus.data_ready, bus.tx_valid, done}); else n_pass++;
    collect(0, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    bus.data_valid = 1'b0;
    n_total++; if ({to, fi, n} !== {1'b0, 32'd1, 32'(NCH)}) $display("FAIL b2b_second_count got=%0d first=%0d to=%b exp=%0d/1", n, fi, to, NCH); else n_pass++;
    n_total++; if (ch !== exp_chips(8'hFF)) $display("FAIL b2b_second_chips got=%h exp=%h", ch, exp_chips(8'hFF)); else n_pass++;
    n_total++; if (sf !== 40'h1) $display("FAIL b2b_second_sof got=%h exp=%h", sf, 40'h1); else n_pass++;
  endtask

  task automatic test_reset_midword();
    logic [NCH-1:0] ch, sf, e;
    int n, fi, dg, sb, bb, stray;
    bit to, ok;
    start_word(8'hC3, 1'b0, ok);
    collect(0, 17, ch, sf, n, fi, dg, sb, bb, to);
    e = exp_chips(8'hC3);
    n_total++; if ({ok, to, n} !== {2'b10, 32'd17}) $display("FAIL midrst_partial got=%0d exp=17", n); else n_pass++;
    n_total++; if (ch[16:0] !== e[16:0]) $display("FAIL midrst_partial_chips got=%h exp=%h", ch[16:0], e[16:0]); else n_pass++;
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_total++; if ({bus.tx_valid, busy} !== 2'b00) $display("FAIL midrst_drop got=%b exp=00", {bus.tx_valid, busy}); else n_pass++;
    @(negedge clk); rst = 1'b0; bus.tx_ready = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b0) stray++;
    end
    n_total++; if (stray !== 0) $display("FAIL midrst_stray_chips got=%0d exp=0", stray); else n_pass++;
    start_word(8'h55, 1'b0, ok);
    collect(0, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    n_total++; if ({ok, to, n} !== {2'b10, 32'(NCH)}) $display("FAIL midrst_next_count got=%0d exp=%0d", n, NCH); else n_pass++;
    n_total++; if (ch !== exp_chips(8'h55)) $display("FAIL midrst_next_chips got=%h exp=%h", ch, exp_chips(8'h55)); else n_pass++;
    n_total++; if (sf !== 40'h1) $display("FAIL midrst_next_sof got=%h exp=%h", sf, 40'h1); else n_pass++;
  endtask

  task automatic test_loopback();
    logic [NCH-1:0] ch, sf;
    logic [DW-1:0]  rec;
    int n, fi, dg, sb, bb, flip, ones;
    bit to, ok;
    start_word(8'h96, 1'b0, ok);
    collect(20, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
    for (int g = 0; g < DW; g++) begin
      flip = $urandom_range(0, RP - 1);
      ones = 0;
      for (int k = 0; k < RP; k++) ones += int'(ch[g * RP + k] ^ (k == flip));
      rec[g] = (ones > RP / 2);
    end
    n_total++; if ({ok, to, n} !== {2'b10, 32'(NCH)}) $display("FAIL loop_count got=%0d exp=%0d", n, NCH); else n_pass++;
    n_total++; if (rec !== 8'h96) $display("FAIL loop_majority got=%h exp=96", rec); else n_pass++;
  endtask

  task automatic test_random();
    logic [NCH-1:0] ch, sf;
    logic [DW-1:0]  w;
    int n, fi, dg, sb, bb, pct;
    bit to, ok;
    for (int t = 0; t < 5; t++) begin
      w   = DW'($urandom_range(0, 255));
      pct = $urandom_range(0, 70);
      start_word(w, 1'b0, ok);
      collect(pct, NCH + 4, ch, sf, n, fi, dg, sb, bb, to);
      n_total++; if ({ok, to, n} !== {2'b10, 32'(NCH)}) $display("FAIL rand_count word=%h got=%0d exp=%0d", w, n, NCH); else n_pass++;
      n_total++; if (ch !== exp_chips(w)) $display("FAIL rand_chips word=%h got=%h exp=%h", w, ch, exp_chips(w)); else n_pass++;
      n_total++; if ({sf, sb} !== {40'h1, 32'd0}) $display("FAIL rand_sof_hold word=%h sof=%h holdviol=%0d exp=%h/0", w, sf, sb, 40'h1); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_ready();
    test_a5();
    test_stall();
    test_back_to_back();
    test_reset_midword();
    test_loopback();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rep5_serial_tx.md
REP5_SERIAL_TX -- requirements
Module: rep5_serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter REP, default 5, chips transmitted per data bit (odd, >=3).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_in  input  DATA_W  word to transmit, sampled on accept.
REQ-006 data_valid  input  1  upstream word available.
REQ-007 data_ready  output  1  block can accept a word; accept = data_valid & data_ready at a rising edge.
REQ-008 tx_bit  output  1  current serial chip.
REQ-009 tx_valid  output  1  tx_bit and tx_sof are valid.
REQ-010 tx_ready  input  1  line side consumes chip; chip transfer = tx_valid & tx_ready at a rising edge.
REQ-011 tx_sof  output  1  high with the first chip of each word only.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  single-cycle pulse after the last chip of a word transfers.

Function
REQ-014 States SHALL be IDLE, SEND, DONE.
REQ-015 IDLE: data_ready=1, tx_valid=0; on accept, capture data_in into a shift register, clear counters, go to SEND.
REQ-016 First chip SHALL be presented (tx_valid=1) in the cycle after the accept edge; latency 1 cycle.
REQ-017 Bit order SHALL be LSB first; tx_bit = shift register bit 0.
REQ-018 Each data bit SHALL be sent as REP consecutive identical chips.
REQ-019 Chip counter counts 0..REP-1 and advances only on a chip transfer; on wrap to 0, shift register shifts right by one and bit counter increments.
REQ-020 Bit counter counts 0..DATA_W-1; a transfer at chip REP-1 of bit DATA_W-1 SHALL move to DONE.
REQ-021 Total chips per word SHALL be exactly DATA_W*REP (40 at defaults).
REQ-022 While tx_valid=1 and tx_ready=0, tx_bit, tx_sof and all counters SHALL hold unchanged.
REQ-023 tx_sof SHALL be 1 only when bit counter=0 and chip counter=0 in SEND.
REQ-024 data_ready SHALL be 0 in SEND and DONE; data_valid there is ignored and data_in not resampled.
REQ-025 DONE: done=1, tx_valid=0 for exactly one cycle, then IDLE unconditionally.
REQ-026 Counters sized ceil(log2(REP)) and ceil(log2(DATA_W)) bits; no wrap beyond terminal values.
REQ-027 tx_ready asserted while tx_valid=0 SHALL have no effect.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counters 0, shift register 0.
REQ-029 Reset outputs: data_ready=0 while rst=1, then 1 in IDLE; tx_valid=0, tx_bit=0, tx_sof=0, busy=0, done=0.
REQ-030 Reset mid-word SHALL abort the word; no further chips of it appear after release.

Structure
REQ-031 Shared package rep5_pkg SHALL hold REP_DEFAULT=5, DATA_W_DEFAULT=8 and the state enumeration type.
REQ-032 One sub-module, rep_mod_counter (parameterised modulo-N counter with enable, terminal-count output, async reset), SHALL implement both chip and bit counters.
REQ-033 Outputs SHALL be registered or decoded only from registered state; no combinational path from data_valid to tx_* outputs.

Verification
REQ-034 Reset: assert rst mid-cycle with no clock -> all outputs at reset values immediately; release -> data_ready=1 next edge.
REQ-035 Word 8'hA5, tx_ready=1 constantly -> 40 chips: 11111 00000 11111 00000 00000 11111 00000 11111, tx_sof on chip 1 only, done one cycle after chip 40.
REQ-036 Word 8'h3C with tx_ready toggling pseudo-randomly -> same chip sequence as ungated case, held chips stable while stalled.
REQ-037 data_valid held high with words 8'h01, 8'hFF -> second word accepted only after done, on the IDLE cycle; no overlap of chips.
REQ-038 rst pulse after chip 17 of 8'hC3 -> tx_valid drops immediately; next word 8'h55 starts with tx_sof and complete 40 chips.
REQ-039 Loopback: chips of 8'h96 grouped by 5, one chip per group flipped, fed to majoritycircuit -> recovered bits equal 8'h96 LSB first.
